// File: rtl/logic_unit.sv
// logic_unit: registered bitwise AND/OR/XOR unit with one-hot opcode.
// Each result port is gated by its own opcode bit; valid/opErr flag the opcode legality.
module logic_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] resultA,
  output logic [WIDTH-1:0] resultO,
  output logic [WIDTH-1:0] resultX,
  output logic             valid,
  output logic             opErr
);

  logic [WIDTH-1:0] res_and_q, res_and_d;
  logic [WIDTH-1:0] res_or_q,  res_or_d;
  logic [WIDTH-1:0] res_xor_q, res_xor_d;
  logic             valid_q,   valid_d;
  logic             op_err_q,  op_err_d;
  logic             one_hot;

  // Next-state: each port loads its function only when its opcode bit is set.
  always_comb begin
    res_and_d = '0;
    res_or_d  = '0;
    res_xor_d = '0;
    one_hot   = (opCode == 3'b001) || (opCode == 3'b010) || (opCode == 3'b100);
    if (opCode[0]) res_and_d = A & B;
    if (opCode[1]) res_or_d  = A | B;
    if (opCode[2]) res_xor_d = A ^ B;
    valid_d  = one_hot;
    op_err_d = !one_hot;
  end

  // Output registers; asynchronous reset clears everything including both flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_and_q <= '0;
      res_or_q  <= '0;
      res_xor_q <= '0;
      valid_q   <= 1'b0;
      op_err_q  <= 1'b0;
    end else begin
      res_and_q <= res_and_d;
      res_or_q  <= res_or_d;
      res_xor_q <= res_xor_d;
      valid_q   <= valid_d;
      op_err_q  <= op_err_d;
    end
  end

  assign resultA = res_and_q;
  assign resultO = res_or_q;
  assign resultX = res_xor_q;
  assign valid   = valid_q;
  assign opErr   = op_err_q;

endmodule

// File: tb/tb_logic_unit.sv
// tb_logic_unit: scoreboard bench; driver pushes reference results, monitor pops and compares.
module tb_logic_unit;

  typedef struct {
    logic [3:0] a;
    logic [3:0] o;
    logic [3:0] x;
    logic       v;
    logic       e;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] opCode;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] resultA;
  logic [3:0] resultO;
  logic [3:0] resultX;
  logic       valid;
  logic       opErr;

  int checks;
  int errors;
  exp_t sb[$];

  logic_unit #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .opCode  (opCode),
    .A       (A),
    .B       (B),
    .resultA (resultA),
    .resultO (resultO),
    .resultX (resultX),
    .valid   (valid),
    .opErr   (opErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model straight from the operation rules.
  function automatic exp_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t r;
    r.a = op[0] ? (a & b) : 4'b0000;
    r.o = op[1] ? (a | b) : 4'b0000;
    r.x = op[2] ? (a ^ b) : 4'b0000;
    r.v = ($countones(op) == 1);
    r.e = ($countones(op) != 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".resultA"}, resultA, e.a);
    chk({tag, ".resultO"}, resultO, e.o);
    chk({tag, ".resultX"}, resultX, e.x);
    chk({tag, ".valid"}, {3'b000, valid}, {3'b000, e.v});
    chk({tag, ".opErr"}, {3'b000, opErr}, {3'b000, e.e});
  endtask

  task automatic chk_zero(input string tag);
    exp_t z;
    z.a = 4'b0000; z.o = 4'b0000; z.x = 4'b0000; z.v = 1'b0; z.e = 1'b0;
    chk_all(tag, z);
  endtask

  // Drive one operation for the coming rising edge and record its expected outcome.
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    opCode = op;
    A      = a;
    B      = b;
    sb.push_back(model(op, a, b));
  endtask

  // Monitor: every edge outside reset should match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() != 0) begin
        e = sb.pop_front();
        chk_all("sb", e);
      end
    end
  end

  initial begin
    logic [3:0] and_a[5] = '{4'b0001, 4'b0011, 4'b1001, 4'b1111, 4'b0000};
    logic [3:0] and_b[5] = '{4'b0001, 4'b0001, 4'b1001, 4'b1111, 4'b0000};
    logic [3:0] or_a[4]  = '{4'b0001, 4'b1001, 4'b0001, 4'b0000};
    logic [3:0] or_b[4]  = '{4'b0101, 4'b0101, 4'b1111, 4'b0101};
    logic [3:0] xor_a[4] = '{4'b1001, 4'b0000, 4'b0000, 4'b1111};
    logic [3:0] xor_b[4] = '{4'b0010, 4'b0000, 4'b0101, 4'b1111};
    int unsigned budget;
    exp_t hand;

    checks = 0;
    errors = 0;

    // Reset with a live operation on the inputs.
    rst_n  = 1'b0;
    opCode = 3'b001;
    A      = 4'b1111;
    B      = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(opCode, A, B));
    @(posedge clk);
    #2;
    chk("release.resultA", resultA, 4'b1111);
    chk("release.valid", {3'b000, valid}, 4'b0001);

    for (int i = 0; i < 5; i++) issue(3'b001, and_a[i], and_b[i]);
    for (int i = 0; i < 4; i++) issue(3'b010, or_a[i], or_b[i]);
    for (int i = 0; i < 4; i++) issue(3'b100, xor_a[i], xor_b[i]);

    // Illegal opcodes, with hand-derived values for the 111 case.
    issue(3'b000, 4'b1010, 4'b0110);
    issue(3'b111, 4'b1010, 4'b0110);
    @(posedge clk);
    #2;
    hand.a = 4'b0010; hand.o = 4'b1110; hand.x = 4'b1100; hand.v = 1'b0; hand.e = 1'b1;
    chk_all("op111", hand);

    // Back-to-back random operations, including illegal opcodes.
    for (int i = 0; i < 200; i++)
      issue(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));

    // Mid-operation reset: outputs must clear without a clock edge.
    issue(3'b111, 4'b1100, 4'b0101);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(opCode, A, B));
    for (int i = 0; i < 20; i++)
      issue(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));

    // Drain with a bounded wait.
    budget = 0;
    while (sb.size() != 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
